// File: rtl/ext_pkg.sv
// Shared definitions for the extension unit: op encoding, lane widths and
// the default value driven for illegal requests.
package ext_pkg;

  localparam int OP_W   = 3;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  localparam logic [63:0] ILLEGAL_DEFAULT = 64'h0000_0000_1234_5678;

  typedef enum logic [OP_W-1:0] {
    EXT_ZERO = 3'd0,
    EXT_SIGN = 3'd1,
    EXT_LUI  = 3'd2,
    EXT_LB   = 3'd3,
    EXT_LBU  = 3'd4,
    EXT_LH   = 3'd5,
    EXT_LHU  = 3'd6,
    EXT_ILL  = 3'd7
  } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// Purely combinational extender: immediate zero/sign/LUI and byte/half load
// lanes. Usable on its own wherever a non-registered extender is needed.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter logic [DATA_W-1:0] ILLEGAL_VAL = DATA_W'(ILLEGAL_DEFAULT),
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic [OP_W-1:0]   op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  // Shifting the word down by the byte offset keeps every lane select in range.
  assign lane_b = BYTE_W'(word >> {off, 3'b000});
  assign lane_h = HALF_W'(word >> {off, 3'b000});

  always_comb begin
    // NOTE: defaults first so every path assigns data/err and no latch is inferred.
    data = ILLEGAL_VAL;
    err  = 1'b1;
    case (ext_op_e'(op))
      EXT_ZERO: begin data = {{(DATA_W-IMM_W){1'b0}}, imm};         err = 1'b0; end
      EXT_SIGN: begin data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}; err = 1'b0; end
      EXT_LUI:  begin data = {imm, {(DATA_W-IMM_W){1'b0}}};         err = 1'b0; end
      EXT_LB:   begin data = {{(DATA_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b}; err = 1'b0; end
      EXT_LBU:  begin data = {{(DATA_W-BYTE_W){1'b0}}, lane_b};           err = 1'b0; end
      EXT_LH: if (!off[0]) begin
        data = {{(DATA_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
        err  = 1'b0;
      end
      EXT_LHU: if (!off[0]) begin
        data = {{(DATA_W-HALF_W){1'b0}}, lane_h};
        err  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered extension stage: ext_core followed by a main output register and
// a skid register, giving full throughput and a registered in_ready.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter logic [DATA_W-1:0] ILLEGAL_VAL = DATA_W'(ILLEGAL_DEFAULT),
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, s_q, new_e;
  logic   accept, xfer;

  ext_core #(
    .DATA_W      (DATA_W),
    .IMM_W       (IMM_W),
    .ILLEGAL_VAL (ILLEGAL_VAL)
  ) u_core (
    .op   (in_op),
    .imm  (in_imm),
    .word (in_word),
    .off  (in_off),
    .data (new_e.data),
    .err  (new_e.err)
  );
  assign new_e.valid = 1'b1;

  // A request arriving together with flush is dropped even if it was accepted.
  assign accept = in_valid && in_ready && !flush;
  assign xfer   = m_q.valid && out_ready;

  always_ff @(posedge clk) begin
    // NOTE: data fields are cleared on reset too, so outputs read zero after
    // reset; otherwise they change only when an entry is loaded.
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      m_q.valid <= 1'b0;
      s_q.valid <= 1'b0;
    end else if (xfer) begin
      if (s_q.valid) begin
        m_q       <= s_q;
        s_q.valid <= 1'b0;
      end else if (accept) begin
        m_q <= new_e;
      end else begin
        m_q.valid <= 1'b0;
      end
    end else if (accept) begin
      // NOTE: non-blocking updates so M and S both see pre-edge values.
      if (!m_q.valid) m_q <= new_e;
      else            s_q <= new_e;
    end
  end

  assign in_ready  = !s_q.valid;
  assign out_valid = m_q.valid;
  assign out_data  = m_q.data;
  assign out_err   = m_q.err;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: expectations queued at input accept and
// compared against the head while the DUT presents a valid result.
module tb_ext_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [31:0] in_word, out_data;
  logic [1:0]  in_off;

  logic        v_in_valid, v_in_ready, v_out_valid, v_out_err;
  logic [2:0]  v_in_op;
  logic [15:0] v_in_imm;
  logic [63:0] v_in_word, v_out_data;
  logic [2:0]  v_in_off;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_cur;

  always #5 clk = ~clk;

  ext_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm),
    .in_word(in_word), .in_off(in_off),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  ext_pipe #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_op(v_in_op), .in_imm(v_in_imm),
    .in_word(v_in_word), .in_off(v_in_off),
    .out_valid(v_out_valid), .out_ready(1'b1), .out_data(v_out_data), .out_err(v_out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference extender: {err, data}
  function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [15:0] imm,
                                          input logic [31:0] word, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = (off == 2'd0) ? word[15:0] : word[31:16];
    case (op)
      3'd0: return {1'b0, 16'h0, imm};
      3'd1: return {1'b0, {16{imm[15]}}, imm};
      3'd2: return {1'b0, imm, 16'h0};
      3'd3: return {1'b0, {24{b[7]}}, b};
      3'd4: return {1'b0, 24'h0, b};
      3'd5: return off[0] ? {1'b1, 32'h12345678} : {1'b0, {16{h[15]}}, h};
      3'd6: return off[0] ? {1'b1, 32'h12345678} : {1'b0, 16'h0, h};
      default: return {1'b1, 32'h12345678};
    endcase
  endfunction

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("state01", {63'b0, out_valid | in_ready}, 64'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("orphan_out", {63'b0, out_valid}, 64'd0);
        end else begin
          check("data", {32'b0, out_data}, {32'b0, exp_q[0][31:0]});
          check("err", {63'b0, out_err}, {63'b0, exp_q[0][32]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(exp_cur);
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] word,
                      input logic [1:0] off, input logic [32:0] exp);
    logic acc;
    in_op = op; in_imm = imm; in_word = word; in_off = off; exp_cur = exp;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", exp_q.size(), 64'd0);
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    send(3'd0, 16'h00AA, 32'h0, 2'd0, {1'b0, 32'h000000AA});
    send(3'd0, 16'h00BB, 32'h0, 2'd0, {1'b0, 32'h000000BB});
    check("in_ready_full", {63'b0, in_ready}, 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [15:0] r_imm;
    logic [31:0] r_word;
    logic [1:0]  r_off;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_imm = '0; in_word = '0; in_off = '0; exp_cur = '0;
    v_in_valid = 1'b0; v_in_op = '0; v_in_imm = '0; v_in_word = '0; v_in_off = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_data", {32'b0, out_data}, 64'd0);
    check("rst_err", {63'b0, out_err}, 64'd0);
    check("rst_ready", {63'b0, in_ready}, 64'd1);

    // Directed immediates, load lanes and errors
    send(3'd1, 16'h8001, 32'h0, 2'd0, {1'b0, 32'hFFFF8001});
    check("lat1_valid", {63'b0, out_valid}, 64'd1);
    send(3'd0, 16'h8001, 32'h0, 2'd0, {1'b0, 32'h00008001});
    send(3'd2, 16'h1234, 32'h0, 2'd0, {1'b0, 32'h12340000});
    send(3'd3, 16'h0, 32'h80FF7F01, 2'd1, {1'b0, 32'h0000007F});
    send(3'd3, 16'h0, 32'h80FF7F01, 2'd2, {1'b0, 32'hFFFFFFFF});
    send(3'd4, 16'h0, 32'h80FF7F01, 2'd3, {1'b0, 32'h00000080});
    send(3'd5, 16'h0, 32'h80FF7F01, 2'd2, {1'b0, 32'hFFFF80FF});
    send(3'd6, 16'h0, 32'h80FF7F01, 2'd0, {1'b0, 32'h00007F01});
    send(3'd5, 16'h0, 32'h80FF7F01, 2'd1, {1'b1, 32'h12345678});
    send(3'd7, 16'h0, 32'h80FF7F01, 2'd0, {1'b1, 32'h12345678});
    drain();

    // Back-pressure: A, B, C, D with out_ready low for three cycles
    send(3'd0, 16'h000A, 32'h0, 2'd0, {1'b0, 32'h0000000A});
    out_ready = 1'b0;
    send(3'd0, 16'h000B, 32'h0, 2'd0, {1'b0, 32'h0000000B});
    check("bp_in_ready", {63'b0, in_ready}, 64'd0);
    fork
      send(3'd0, 16'h000C, 32'h0, 2'd0, {1'b0, 32'h0000000C});
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(3'd0, 16'h000D, 32'h0, 2'd0, {1'b0, 32'h0000000D});
    drain();

    // Random traffic against the reference with random back-pressure
    fork
      for (int i = 0; i < 16; i++) begin
        r_op = 3'($urandom); r_imm = 16'($urandom); r_word = $urandom; r_off = 2'($urandom);
        send(r_op, r_imm, r_word, r_off, ref_ext(r_op, r_imm, r_word, r_off));
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Flush while FULL with a request presented
    fill_full();
    in_op = 3'd0; in_imm = 16'h00EE; exp_cur = {1'b0, 32'h000000EE};
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    check("flush_valid", {63'b0, out_valid}, 64'd0);
    check("flush_ready", {63'b0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1 check("flush_ghost", {63'b0, out_valid}, 64'd0);

    // Reset while FULL, dominating flush and a presented request
    fill_full();
    in_op = 3'd1; in_imm = 16'hFFFF; in_valid = 1'b1; flush = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    check("mrst_valid", {63'b0, out_valid}, 64'd0);
    check("mrst_data", {32'b0, out_data}, 64'd0);
    check("mrst_err", {63'b0, out_err}, 64'd0);
    check("mrst_ready", {63'b0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 check("mrst_ghost", {63'b0, out_valid}, 64'd0);

    // 64-bit variant: top byte lane
    v_in_op = 3'd3; v_in_off = 3'd7; v_in_word = 64'h8100_0000_0000_0000; v_in_valid = 1'b1;
    @(posedge clk);
    #1 v_in_valid = 1'b0;
    check("w64_valid", {63'b0, v_out_valid}, 64'd1);
    check("w64_lb7", v_out_data, 64'hFFFF_FFFF_FFFF_FF81);
    check("w64_err", {63'b0, v_out_err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
